// File: rtl/commit_checker.sv
// Commit-stream checker: compares each retired instruction and its register
// write-back against a preloaded golden trace and reports the first divergence.
//
// state  | meaning
// IDLE   | waiting for start; trace memory writable
// RUN    | consuming commits, trace memory write-protected
// PASS   | all expected commits matched
// FAIL   | first mismatch or timeout latched in fail_code/fail_index
module commit_checker #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 4096
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W:0]     trace_len,
    input  logic                trace_wr_en,
    input  logic [ADDR_W-1:0]   trace_wr_addr,
    input  logic [96:0]         trace_wr_data,
    input  logic                commit_valid,
    input  logic [31:0]         commit_pc,
    input  logic [31:0]         commit_inst,
    input  logic [1023:0]       reg_state,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic [2:0]          fail_code,
    output logic [ADDR_W:0]     fail_index,
    output logic [ADDR_W:0]     commit_count
);

    localparam int CW = ADDR_W + 1;
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t          state;
    logic [CW-1:0]   len_q;
    logic [IW-1:0]   idle_cnt;
    logic            s2_valid;
    logic            s2_wen;
    logic [4:0]      s2_rd;
    logic [31:0]     s2_wdata;
    logic [CW-1:0]   s2_index;

    logic [96:0]     trace_mem [0:(1<<ADDR_W)-1];
    logic [96:0]     entry;
    logic            s1_active, pc_bad, inst_bad, s1_match, s2_bad, timeout_hit;

    always_ff @(posedge clock) begin
        if (trace_wr_en && state != S_RUN)
            trace_mem[trace_wr_addr] <= trace_wr_data;
    end

    assign entry = trace_mem[commit_count[ADDR_W-1:0]];

    // Commits past the end of the trace are ignored rather than flagged.
    assign s1_active   = (state == S_RUN) && commit_valid && (commit_count != len_q);
    assign pc_bad      = s1_active && (commit_pc != entry[95:64]);
    assign inst_bad    = s1_active && !pc_bad && (commit_inst != entry[63:32]);
    assign s1_match    = s1_active && !pc_bad && !inst_bad;
    assign s2_bad      = s2_valid && s2_wen && (s2_rd != 5'd0) &&
                         (reg_state[{s2_rd, 5'd0} +: 32] != s2_wdata);
    assign timeout_hit = (state == S_RUN) && !commit_valid &&
                         (idle_cnt == IW'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            len_q        <= '0;
            idle_cnt     <= '0;
            s2_valid     <= 1'b0;
            s2_wen       <= 1'b0;
            s2_rd        <= '0;
            s2_wdata     <= '0;
            s2_index     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            fail_code    <= '0;
            fail_index   <= '0;
            commit_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_PASS, S_FAIL: begin
                    if (start) begin
                        len_q        <= trace_len;
                        commit_count <= '0;
                        fail_code    <= '0;
                        fail_index   <= '0;
                        idle_cnt     <= '0;
                        s2_valid     <= 1'b0;
                        fail         <= 1'b0;
                        if (trace_len == '0) begin
                            state <= S_PASS;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    s2_valid <= 1'b0;
                    idle_cnt <= commit_valid ? '0 : idle_cnt + IW'(1);
                    // Stage 2 belongs to the older commit, so it takes priority.
                    if (s2_bad || pc_bad || inst_bad || timeout_hit) begin
                        state <= S_FAIL;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        fail  <= 1'b1;
                        if (s2_bad) begin
                            fail_code  <= 3'd3;
                            fail_index <= s2_index;
                        end else begin
                            fail_code  <= pc_bad ? 3'd1 : (inst_bad ? 3'd2 : 3'd4);
                            fail_index <= commit_count;
                        end
                    end else if (s1_match) begin
                        commit_count <= commit_count + CW'(1);
                        s2_valid     <= 1'b1;
                        s2_wen       <= entry[96];
                        s2_wdata     <= entry[31:0];
                        s2_rd        <= commit_inst[11:7];
                        s2_index     <= commit_count;
                    end else if (commit_count == len_q) begin
                        state <= S_PASS;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_checker.sv
// Scenario bench for commit_checker: expected final verdicts are queued at
// start and popped when the checker reports done; timing is checked inline.
module tb_commit_checker;

    localparam logic [31:0] I0 = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I1 = 32'h00108113;  // addi x2,x1,1
    localparam logic [31:0] I2 = 32'h00202023;  // sw x2,0(x0)
    localparam logic [31:0] I3 = 32'h00700013;  // addi x0,x0,7

    typedef struct packed {
        logic        pass;
        logic [2:0]  code;
        logic [10:0] idx;
        logic [10:0] cnt;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [10:0]   trace_len = '0;
    logic          trace_wr_en = 1'b0;
    logic [9:0]    trace_wr_addr = '0;
    logic [96:0]   trace_wr_data = '0;
    logic          commit_valid = 1'b0;
    logic [31:0]   commit_pc = '0;
    logic [31:0]   commit_inst = '0;
    logic [1023:0] reg_state = '0;
    logic          busy, done, pass, fail;
    logic [2:0]    fail_code;
    logic [10:0]   fail_index, commit_count;

    int   compared = 0;
    int   mismatched = 0;
    exp_t sb_q[$];

    commit_checker #(.ADDR_W(10), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .start(start), .trace_len(trace_len),
        .trace_wr_en(trace_wr_en), .trace_wr_addr(trace_wr_addr),
        .trace_wr_data(trace_wr_data), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_inst(commit_inst), .reg_state(reg_state),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .fail_code(fail_code), .fail_index(fail_index), .commit_count(commit_count)
    );

    always #5 clock = ~clock;

    task automatic load_entry(input logic [9:0] a, input logic w, input logic [31:0] pc,
                              input logic [31:0] inst, input logic [31:0] wd);
        trace_wr_en   = 1'b1;
        trace_wr_addr = a;
        trace_wr_data = {w, pc, inst, wd};
        @(negedge clock);
        trace_wr_en   = 1'b0;
    endtask

    task automatic load_base();
        load_entry(10'd0, 1'b1, 32'h0, I0, 32'd5);
        load_entry(10'd1, 1'b1, 32'h4, I1, 32'd6);
        load_entry(10'd2, 1'b0, 32'h8, I2, 32'd0);
    endtask

    task automatic do_start(input logic [10:0] len);
        start     = 1'b1;
        trace_len = len;
        @(negedge clock);
        start     = 1'b0;
    endtask

    task automatic step(input logic cv, input logic [31:0] pc, input logic [31:0] inst);
        commit_valid = cv;
        commit_pc    = pc;
        commit_inst  = inst;
        @(negedge clock);
        commit_valid = 1'b0;
    endtask

    task automatic set_x(input int idx, input logic [31:0] val);
        reg_state[idx*32 +: 32] = val;
    endtask

    task automatic expect_result(input logic p, input logic [2:0] c,
                                 input logic [10:0] i, input logic [10:0] n);
        exp_t e;
        e.pass = p; e.code = c; e.idx = i; e.cnt = n;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int   n;
        exp_t e;
        exp_t got;
        n = 0;
        while (!done && n < 64) begin
            @(negedge clock);
            n++;
        end
        compared++;
        if (sb_q.size() == 0) begin
            mismatched++;
            $display("FAIL %s: scoreboard empty, nothing expected", name);
        end else begin
            e = sb_q.pop_front();
            if (done !== 1'b1) begin
                mismatched++;
                $display("FAIL %s: done never asserted within 64 cycles", name);
            end else begin
                got.pass = pass; got.code = fail_code; got.idx = fail_index; got.cnt = commit_count;
                if (got !== e || fail !== !e.pass) begin
                    mismatched++;
                    $display("FAIL %s: got pass=%0b fail=%0b code=%0d idx=%0d cnt=%0d, want pass=%0b code=%0d idx=%0d cnt=%0d",
                             name, pass, fail, fail_code, fail_index, commit_count,
                             e.pass, e.code, e.idx, e.cnt);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [28:0] obs;
        obs = {busy, done, pass, fail, fail_code, fail_index, commit_count};
        compared++;
        if (obs !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h, want 0", obs);
        end
    endtask

    task automatic test_back_to_back();
        reg_state = '0;
        load_base();
        expect_result(1'b1, 3'd0, 11'd0, 11'd3);
        do_start(11'd3);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_busy: got %0b, want 1", busy);
        end
        // A trace write while running must be dropped; corrupt entry 2 if it lands.
        trace_wr_en   = 1'b1;
        trace_wr_addr = 10'd2;
        trace_wr_data = {1'b0, 32'hDEAD, 32'h0, 32'h0};
        step(1'b1, 32'h0, I0);
        trace_wr_en = 1'b0;
        set_x(1, 32'd5);
        step(1'b1, 32'h4, I1);
        set_x(2, 32'd6);
        step(1'b1, 32'h8, I2);
        compared++;
        if (pass !== 1'b0 || commit_count !== 11'd3) begin
            mismatched++;
            $display("FAIL b2b_early: got pass=%0b cnt=%0d, want pass=0 cnt=3", pass, commit_count);
        end
        step(1'b0, 32'h0, 32'h0);
        compared++;
        if (pass !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_pass_timing: got pass=%0b, want 1 two edges after last commit", pass);
        end
        wait_done("back_to_back");
    endtask

    task automatic test_pc_mismatch();
        reg_state = '0;
        expect_result(1'b0, 3'd1, 11'd1, 11'd1);
        do_start(11'd3);
        step(1'b1, 32'h0, I0);
        set_x(1, 32'd5);
        step(1'b1, 32'h8, I1);
        compared++;
        if (fail !== 1'b1) begin
            mismatched++;
            $display("FAIL pc_fail_timing: got fail=%0b, want 1 one edge after bad commit", fail);
        end
        wait_done("pc_mismatch");
    endtask

    task automatic test_inst_mismatch();
        reg_state = '0;
        expect_result(1'b0, 3'd2, 11'd0, 11'd0);
        do_start(11'd3);
        step(1'b1, 32'h0, I1);
        wait_done("inst_mismatch");
    endtask

    task automatic test_reg_mismatch();
        reg_state = '0;
        expect_result(1'b0, 3'd3, 11'd0, 11'd1);
        do_start(11'd3);
        step(1'b1, 32'h0, I0);
        set_x(1, 32'd4);
        step(1'b1, 32'h4, I1);
        wait_done("reg_mismatch_older_wins");
    endtask

    task automatic test_timeout();
        reg_state = '0;
        expect_result(1'b0, 3'd4, 11'd1, 11'd1);
        do_start(11'd2);
        step(1'b1, 32'h0, I0);
        set_x(1, 32'd5);
        repeat (15) step(1'b0, 32'h0, 32'h0);
        compared++;
        if (fail !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_early: got fail=%0b busy=%0b after 15 idle, want 0/1", fail, busy);
        end
        step(1'b0, 32'h0, 32'h0);
        compared++;
        if (fail !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_exact: got fail=%0b after 16 idle, want 1", fail);
        end
        wait_done("timeout");
    endtask

    task automatic test_zero_len();
        expect_result(1'b1, 3'd0, 11'd0, 11'd0);
        do_start(11'd0);
        compared++;
        if ({busy, pass} !== 2'b01) begin
            mismatched++;
            $display("FAIL zero_len: got busy=%0b pass=%0b, want busy=0 pass=1", busy, pass);
        end
        wait_done("zero_len");
    endtask

    task automatic test_x0_write();
        reg_state = '0;
        load_entry(10'd0, 1'b1, 32'h100, I3, 32'd7);
        expect_result(1'b1, 3'd0, 11'd0, 11'd1);
        do_start(11'd1);
        step(1'b1, 32'h100, I3);
        step(1'b0, 32'h0, 32'h0);
        wait_done("x0_unchecked");
    endtask

    task automatic test_reset_midrun();
        logic [28:0] obs;
        reg_state = '0;
        load_base();
        do_start(11'd3);
        step(1'b1, 32'h0, I0);
        set_x(1, 32'd5);
        #2 reset = 1'b1;
        #1;
        obs = {busy, done, pass, fail, fail_code, fail_index, commit_count};
        compared++;
        if (obs !== '0) begin
            mismatched++;
            $display("FAIL reset_midrun: got %h, want 0", obs);
        end
        @(negedge clock);
        reset = 1'b0;
        reg_state = '0;
        load_entry(10'd0, 1'b1, 32'h0, I0, 32'd5);
        expect_result(1'b1, 3'd0, 11'd0, 11'd3);
        do_start(11'd3);
        step(1'b1, 32'h0, I0);
        set_x(1, 32'd5);
        step(1'b1, 32'h4, I1);
        set_x(2, 32'd6);
        step(1'b1, 32'h8, I2);
        step(1'b0, 32'h0, 32'h0);
        wait_done("after_reset_rerun");
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_back_to_back();
        test_pc_mismatch();
        test_inst_mismatch();
        test_reg_mismatch();
        test_timeout();
        test_zero_len();
        test_x0_write();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/commit_checker.md
Name: commit_checker

Overview:
- Sits on the far side of the core's architectural-state interface (commit, pc, inst, and the 32-entry integer register state) and consumes the commit stream.
- Compares every committed instruction against a golden trace held in an internal trace memory, which the bench loads before the run.
- Reports pass or fail, the index of the first mismatching commit, and the mismatch kind.
- Lets bare-metal tests self-check in simulation without a software reference model.

Parameters:
- ADDR_W, 10: trace index width; the trace memory holds 2^ADDR_W entries.
- TIMEOUT, 4096: idle cycles allowed in RUN with no commit before declaring failure.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse that arms the checker
- trace_len  in  ADDR_W+1  number of commits expected; sampled on start
- trace_wr_en  in  1  trace memory write strobe
- trace_wr_addr  in  ADDR_W  trace entry index
- trace_wr_data  in  97  entry fields: [96] wen, [95:64] pc, [63:32] inst, [31:0] wdata
- commit_valid  in  1  core commit strobe
- commit_pc  in  32  pc of the committing instruction
- commit_inst  in  32  instruction word of the committing instruction
- reg_state  in  1024  flattened register file; x[i] occupies bits [32i+31:32i]
- busy  out  1  asserted in RUN
- done  out  1  asserted in PASS or FAIL
- pass  out  1  asserted in PASS
- fail  out  1  asserted in FAIL
- fail_code  out  3  0 none, 1 pc mismatch, 2 inst mismatch, 3 register value mismatch, 4 timeout
- fail_index  out  ADDR_W+1  trace index of the first failure
- commit_count  out  ADDR_W+1  number of commits consumed in the current run

Behaviour:
- Reset: state IDLE. All outputs are 0, including the idle counter and the stage-2 valid flag. Trace memory contents are not reset.
- Trace memory:
  - Register array with combinational read at index commit_count.
  - Writes take effect on the clock edge and are accepted in every state except RUN; writes during RUN are dropped.
- FSM states: IDLE, RUN, PASS, FAIL.
  - IDLE, PASS or FAIL with start=1: latch trace_len, clear commit_count, fail_code, fail_index and the idle counter, then go to RUN.
  - If trace_len==0, go straight to PASS instead of RUN.
  - start while in RUN is ignored.
- Stage 1 (cycle of commit_valid, state RUN):
  - Compare commit_pc with entry.pc; if unequal, the failure code is 1.
  - Otherwise compare commit_inst with entry.inst; if unequal, the failure code is 2.
  - On a match, register entry.wen, entry.wdata, rd=commit_inst[11:7] and the index into stage 2, and increment commit_count.
- Stage 2 (exactly one cycle after the stage-1 match):
  - The core's reg_state shows the committed write one cycle after commit.
  - If wen=1 and rd!=0, compare reg_state[rd] with wdata; if unequal, the failure code is 3.
  - rd==0 or wen=0 is never checked.
- Back-to-back commits: one commit per cycle is supported at full rate. Stage 2 of commit k overlaps stage 1 of commit k+1.
- Simultaneous failures: the stage-2 failure (the older commit) wins, and fail_index is its index.
- On any failure:
  - Go to FAIL next edge.
  - Latch fail_code and fail_index.
  - commit_count freezes.
  - In-flight stage-2 work is discarded.
- PASS condition: commit_count==trace_len and no stage-2 check pending or failing. The entry into PASS happens after the final stage-2 check completes, so the final commit reaches PASS two edges after its commit_valid.
- Commits arriving when commit_count==trace_len are ignored. The same applies to commits in IDLE, PASS or FAIL.
- Timeout:
  - The idle counter increments each RUN cycle without commit_valid and clears on commit_valid.
  - When it reaches TIMEOUT-1 while commit_valid=0, go to FAIL with code 4 and fail_index=commit_count.
- Outputs are registered and hold in PASS and FAIL until the next start or reset.
- Reset asserted mid-run aborts immediately to IDLE with all outputs 0.

Test Plan:
- Load 3 entries: {pc 0x0, addi x1,x0,5, wen 1, wdata 5}, {pc 0x4, addi x2,x1,1, wen 1, wdata 6}, {pc 0x8, sw, wen 0}. Set trace_len=3 and start, drive the 3 commits back to back with matching reg_state one cycle later -> pass=1 two edges after the third commit, commit_count=3, fail_code=0.
- Same trace, second commit pc=0x8 -> fail=1, fail_code=1, fail_index=1, commit_count=1.
- Same trace, x1 shows 4 instead of 5 in the cycle after commit 0, while commit 1 matches in that same cycle -> fail_code=3, fail_index=0 (older commit wins).
- TIMEOUT=16, trace_len=2, only one commit driven -> fail_code=4, fail_index=1, exactly 16 cycles after that commit.
- trace_len=0 with start -> pass=1 one edge later and busy never asserts. Entry for addi x0,x0,7 with wdata 7 while x0 reads 0 -> no failure.
- Assert reset mid-run after 1 of 3 commits -> all outputs 0 immediately. Then a trace write followed by start -> a clean run passes.
